// File: rtl/operand_feeder_ram_if.sv
// Load/stream bus for operand_feeder_ram.
// master drives writes and stream requests; slave returns lane operands.
interface operand_feeder_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int LANES  = 4
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                    wr_en;
    logic [LW-1:0]           wr_lane;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    start;
    logic [ADDR_W-1:0]       rd_base;
    logic [ADDR_W:0]         rd_len;
    logic                    busy;
    logic                    done;
    logic [LANES-1:0]        lane_valid;
    logic [LANES*DATA_W-1:0] lane_data;

    modport master (
        output wr_en, wr_lane, wr_addr, wr_data,
        output start, rd_base, rd_len,
        input  busy, done, lane_valid, lane_data
    );

    modport slave (
        input  wr_en, wr_lane, wr_addr, wr_data,
        input  start, rd_base, rd_len,
        output busy, done, lane_valid, lane_data
    );
endinterface

// File: rtl/operand_feeder_ram.sv
// Banked operand RAM streaming one word per lane per cycle into a systolic array.
// OPERAND_FEEDER_SKEW_EN delays lane i by i cycles (diagonal skew).
module operand_feeder_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int LANES  = 4
) (
    input logic                clk,
    input logic                rst_n,
    operand_feeder_ram_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef OPERAND_FEEDER_SKEW_EN
    localparam int DRAIN_N = LANES;
`else
    localparam int DRAIN_N = 1;
`endif
    localparam int DCW = $clog2(DRAIN_N + 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DCW-1:0]    dcnt_q, dcnt_d;
    logic              done_q, done_d;
    logic              rvalid_q, rvalid_d;
    logic [ADDR_W:0]   len_sat;
    logic              start_ok;
    logic              rd_en;
    logic              busy;

    logic              lane_v [LANES];
    logic [DATA_W-1:0] lane_w [LANES];

    // A start coinciding with the done pulse still belongs to the old stream.
    assign start_ok = bus.start && (state_q == IDLE) && !done_q;
    assign len_sat  = (bus.rd_len > (ADDR_W+1)'(DEPTH)) ?
                      (ADDR_W+1)'(DEPTH) : bus.rd_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            dcnt_q   <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            dcnt_q   <= dcnt_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok && (len_sat != '0)) begin
                    state_d = STREAM;
                    cnt_d   = len_sat;
                    addr_d  = bus.rd_base;
                end
            end
            STREAM: begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - (ADDR_W+1)'(1);
                if (cnt_q == (ADDR_W+1)'(1)) begin
                    state_d = DRAIN;
                    dcnt_d  = DCW'(DRAIN_N - 1);
                end
            end
            DRAIN: begin
                if (dcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q - DCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en    = (state_q == STREAM);
        busy     = (state_q != IDLE);
        rvalid_d = rd_en;
        done_d   = 1'b0;
        if ((state_q == DRAIN) && (dcnt_q == '0)) begin
            done_d = 1'b1;
        end
        if (start_ok && (len_sat == '0)) begin
            done_d = 1'b1;
        end
    end

    for (genvar b = 0; b < LANES; b++) begin : g_lane
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [DATA_W-1:0] rd_q, rd_d;
        logic              we;

        assign we = bus.wr_en && !busy && (bus.wr_lane == LW'(b));

        // Storage survives reset; only the read path is cleared.
        always_ff @(posedge clk) begin
            if (we) begin
                mem_q[bus.wr_addr] <= bus.wr_data;
            end
        end

        always_comb begin
            rd_d = rd_q;
            if (rd_en) begin
                rd_d = mem_q[addr_q];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

`ifdef OPERAND_FEEDER_SKEW_EN
        if (b == 0) begin : g_direct
            assign lane_v[b] = rvalid_q;
            assign lane_w[b] = rd_q;
        end else begin : g_skew
            logic [DATA_W-1:0] sd_q [b];
            logic [DATA_W-1:0] sd_d [b];
            logic [b-1:0]      sv_q, sv_d;

            always_comb begin
                sd_d[0] = rd_q;
                sv_d[0] = rvalid_q;
                for (int j = 1; j < b; j++) begin
                    sd_d[j] = sd_q[j-1];
                    sv_d[j] = sv_q[j-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sv_q <= '0;
                    for (int j = 0; j < b; j++) begin
                        sd_q[j] <= '0;
                    end
                end else begin
                    sv_q <= sv_d;
                    sd_q <= sd_d;
                end
            end

            assign lane_v[b] = sv_q[b-1];
            assign lane_w[b] = sd_q[b-1];
        end
`else
        assign lane_v[b] = rvalid_q;
        assign lane_w[b] = rd_q;
`endif
    end

    always_comb begin
        bus.lane_valid = '0;
        bus.lane_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.lane_valid[i] = lane_v[i];
            if (lane_v[i]) begin
                bus.lane_data[i*DATA_W +: DATA_W] = lane_w[i];
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;

endmodule

// File: tb/tb_operand_feeder_ram.sv
// Scoreboard bench for operand_feeder_ram: per-lane expected words and
// done cycles are queued at stimulus time and checked cycle-exactly.
module tb_operand_feeder_ram;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int LANES  = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef OPERAND_FEEDER_SKEW_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif
    localparam int DRAIN = SK ? LANES : 1;

    typedef struct {
        int               cyc;
        logic [DATA_W-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   bfrom = 0;
    int   bto = -1;

    logic [DATA_W-1:0] model [LANES][DEPTH];
    exp_t lq [LANES][$];
    int   dq [$];

    operand_feeder_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

    operand_feeder_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LANES (LANES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit de;
        check("busy", longint'(bus.busy), longint'((cyc >= bfrom) && (cyc <= bto)));
        de = (dq.size() > 0) && (dq[0] == cyc);
        check("done", longint'(bus.done), longint'(de));
        if (de) void'(dq.pop_front());
        for (int i = 0; i < LANES; i++) begin
            if ((lq[i].size() > 0) && (lq[i][0].cyc == cyc)) begin
                exp_t e;
                e = lq[i].pop_front();
                check($sformatf("vld%0d", i), longint'(bus.lane_valid[i]), 1);
                check($sformatf("dat%0d", i), longint'(bus.lane_data[i*DATA_W +: DATA_W]),
                      longint'(e.d));
            end else begin
                check($sformatf("vld%0d", i), longint'(bus.lane_valid[i]), 0);
                check($sformatf("zero%0d", i), longint'(bus.lane_data[i*DATA_W +: DATA_W]), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int lane, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_lane = 2'(lane);
        bus.wr_addr = 4'(addr);
        bus.wr_data = 16'(data);
        model[lane][addr] = 16'(data);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic start_stream(input int base, input int len, input bit acc);
        int n;
        int t;
        bus.start   = 1'b1;
        bus.rd_base = 4'(base);
        bus.rd_len  = 5'(len);
        t = cyc;
        if (acc) begin
            n = (len > DEPTH) ? DEPTH : len;
            if (n == 0) begin
                dq.push_back(t + 1);
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    for (int k = 0; k < n; k++) begin
                        exp_t e;
                        e.cyc = t + 2 + SK * i + k;
                        e.d   = model[i][(base + k) % DEPTH];
                        lq[i].push_back(e);
                    end
                end
                dq.push_back(t + n + DRAIN + 1);
                bfrom = t + 1;
                bto   = t + n + DRAIN;
            end
        end
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        int left;
        bit empty;
        left = 300;
        empty = 1'b0;
        while (!empty && left > 0) begin
            empty = (dq.size() == 0);
            for (int i = 0; i < LANES; i++) begin
                if (lq[i].size() != 0) empty = 1'b0;
            end
            if (!empty) begin
                step();
                left--;
            end
        end
        check("drain_timeout", longint'(empty), 1);
        step();
    endtask

    initial begin
        int t0;
        bus.wr_en   = 1'b0;
        bus.wr_lane = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.rd_base = '0;
        bus.rd_len  = '0;
        repeat (3) step();
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_vld", longint'(bus.lane_valid), 0);
        check("rst_dat", longint'(bus.lane_data), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                write_word(i, k, 16 * i + k);
            end
        end
        step();

        start_stream(0, 3, 1'b1);
        wait_drain();
        start_stream(14, 4, 1'b1);
        wait_drain();
        start_stream(9, 0, 1'b1);
        wait_drain();

        // writes and starts during a stream are dropped
        start_stream(0, 5, 1'b1);
        step();
        bus.wr_en   = 1'b1;
        bus.wr_lane = 2'd0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 16'hFFFF;
        start_stream(7, 3, 1'b0);
        wait_drain();
        start_stream(0, 1, 1'b1);
        wait_drain();

        // start in the done cycle is ignored, the next cycle is accepted
        t0 = cyc;
        start_stream(2, 2, 1'b1);
        while (cyc < t0 + 2 + DRAIN + 1) step();
        start_stream(11, 2, 1'b0);
        start_stream(5, 2, 1'b1);
        wait_drain();

        // same-cycle write and start: stream sees the new word
        bus.wr_en   = 1'b1;
        bus.wr_lane = 2'd1;
        bus.wr_addr = 4'd3;
        bus.wr_data = 16'h1234;
        model[1][3] = 16'h1234;
        start_stream(3, 1, 1'b1);
        wait_drain();

        // async reset mid-stream
        start_stream(0, 8, 1'b1);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("mid_busy", longint'(bus.busy), 0);
        check("mid_done", longint'(bus.done), 0);
        check("mid_vld", longint'(bus.lane_valid), 0);
        check("mid_dat", longint'(bus.lane_data), 0);
        for (int i = 0; i < LANES; i++) lq[i].delete();
        dq.delete();
        bto = -1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        start_stream(2, 2, 1'b1);
        wait_drain();

        start_stream(0, 20, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
